// File: rtl/alu_pkg.sv
// Shared ALU function codes and sequencer state encoding.
// Bit 0 of an add/sub code substitutes b=1, which gives increment and decrement.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_INC = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_DEC = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_SHF = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_seq_counter.sv
// Iteration and settle-wait down-counters for the ALU sequencer.
// o_settle_done marks the cycle where the ALU result is sampled; o_last_iter marks the final pass.
module alu_seq_counter #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_run,
  output logic             o_last_iter,
  output logic             o_settle_done
);

  localparam int WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ALU_LAT - 1);

  logic [CNT_W-1:0]  r_iter;
  logic [WAIT_W-1:0] r_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iter <= '0;
      r_wait <= '0;
    end else if (i_load) begin
      // A count of zero still runs the operation once.
      r_iter <= (i_count == '0) ? CNT_W'(1) : i_count;
      r_wait <= WAIT_INIT;
    end else if (i_run) begin
      if (r_wait != '0) begin
        r_wait <= r_wait - WAIT_W'(1);
      end else begin
        r_iter <= r_iter - CNT_W'(1);
        r_wait <= WAIT_INIT;
      end
    end
  end

  assign o_last_iter   = (r_iter == CNT_W'(1));
  assign o_settle_done = (r_wait == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-driven initiator for a combinational 32-bit ALU: registers operands, waits the
// settle time, chains repeated results through operand A and returns the final value.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_use_acc,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_zero,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_f,
  input  logic [31:0]      alu_r
);

  seq_state_t  r_state;
  seq_state_t  w_state_next;
  logic        w_idle_ready;
  logic        w_accept;
  logic        w_capture;
  logic        w_finish;
  logic        w_resp_done;
  logic        w_run;
  logic        w_last_iter;
  logic        w_settle_done;

  logic [31:0] r_acc;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_f;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_zero;

  alu_seq_counter #(
    .ALU_LAT (ALU_LAT),
    .CNT_W   (CNT_W)
  ) u_counter (
    .clk           (clk),
    .reset         (reset),
    .i_load        (w_accept),
    .i_count       (cmd_count),
    .i_run         (w_run),
    .o_last_iter   (w_last_iter),
    .o_settle_done (w_settle_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idle_ready = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_finish     = 1'b0;
    w_resp_done  = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle_ready = 1'b1;
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_run = 1'b1;
        if (w_settle_done) begin
          w_capture = 1'b1;
          if (w_last_iter) begin
            w_finish     = 1'b1;
            w_state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_resp_done  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_f     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_alu_a <= cmd_use_acc ? r_acc : cmd_a;
        r_alu_b <= cmd_b;
        r_alu_f <= cmd_op;
      end
      if (w_capture) begin
        r_acc <= alu_r;
        if (w_finish) begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= alu_r;
          r_rsp_zero  <= (alu_r == 32'd0);
        end else begin
          // Chain the intermediate result; b and f stay put for the next pass.
          r_alu_a <= alu_r;
        end
      end
      if (w_resp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Gated by reset so the host never sees a ready that cannot be honoured.
  assign cmd_ready = w_idle_ready & ~reset;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_f     = r_alu_f;

endmodule
